// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers a group of exponent approximations, reports their sum,
// then scales each element by an externally supplied reciprocal (m * 2^-k) with rounding.
module softmax_normalizer #(
    parameter int MANT_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [MANT_WIDTH-1:0]                 in_data,
    output logic                                  in_ready,
    output logic [MANT_WIDTH+$clog2(DEPTH)-1:0]   sum_out,
    output logic                                  sum_valid,
    input  logic                                  recip_valid,
    input  logic [MANT_WIDTH-1:0]                 recip_mant,
    input  logic [2:0]                            recip_shift,
    output logic                                  out_valid,
    output logic [MANT_WIDTH-1:0]                 out_data,
    output logic                                  out_last,
    input  logic                                  out_ready
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SUM_W  = MANT_WIDTH + IDX_W;
    localparam int PROD_W = 2 * MANT_WIDTH + 1;

    typedef enum logic [1:0] {
        FILL,
        WAIT_RECIP,
        EMIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_W-1:0]      idx;
    logic [SUM_W-1:0]      sum;
    logic [MANT_WIDTH-1:0] buffer [DEPTH];
    logic [MANT_WIDTH-1:0] m_q;
    logic [2:0]            k_q;
    logic                  accept;
    logic                  last_in;
    logic                  recip_take;
    logic                  out_take;

    // Round half-up on the k discarded bits, then clamp to the output range.
    function automatic logic [MANT_WIDTH-1:0] scale(
        input logic [MANT_WIDTH-1:0] e,
        input logic [MANT_WIDTH-1:0] m,
        input logic [2:0]            k
    );
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] r;
        p = PROD_W'(e) * PROD_W'(m);
        if (k != 3'd0) begin
            p = p + (PROD_W'(1) << (k - 3'd1));
        end
        r = p >> k;
        if (r > PROD_W'({MANT_WIDTH{1'b1}})) begin
            return '1;
        end
        return r[MANT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last_in    = 1'b0;
        recip_take = 1'b0;
        out_take   = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                last_in  = in_valid && (idx == IDX_W'(DEPTH - 1));
                if (last_in) begin
                    state_next = WAIT_RECIP;
                end
            end
            WAIT_RECIP: begin
                recip_take = recip_valid;
                if (recip_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_take = out_valid && out_ready;
                if (out_take && out_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[idx] <= in_data;
        end
    end

    // idx counts accepted elements in FILL and names the next element to present in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            sum       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            m_q       <= '0;
            k_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (accept) begin
                sum <= sum + SUM_W'(in_data);
                idx <= idx + IDX_W'(1);
                if (last_in) begin
                    sum_out   <= sum + SUM_W'(in_data);
                    sum_valid <= 1'b1;
                end
            end
            if (recip_take) begin
                m_q       <= recip_mant;
                k_q       <= recip_shift;
                out_data  <= scale(buffer[0], recip_mant, recip_shift);
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                idx       <= IDX_W'(1);
            end
            if (out_take) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    idx       <= '0;
                    sum       <= '0;
                end else begin
                    out_data <= scale(buffer[idx], m_q, k_q);
                    out_last <= (idx == IDX_W'(DEPTH - 1));
                    idx      <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/softmax_normalizer.md
SOFTMAX_NORMALIZER -- requirements
Module: softmax_normalizer

Interface
REQ-001 SHALL have parameter MANT_WIDTH, default 8, the element, reciprocal-mantissa and output data width.
REQ-002 SHALL have parameter DEPTH, default 4, the elements per normalization group (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  the element on in_data is offered.
REQ-006 SHALL have port in_data  input  MANT_WIDTH  unsigned exponent-approximation element e_i.
REQ-007 SHALL have port in_ready  output  1  the block accepts an element this cycle.
REQ-008 SHALL have port sum_out  output  MANT_WIDTH+log2(DEPTH)  unsigned group sum S.
REQ-009 SHALL have port sum_valid  output  1  one-cycle pulse: sum_out holds the final S.
REQ-010 SHALL have port recip_valid  input  1  recip_mant and recip_shift are valid (single-cycle strobe).
REQ-011 SHALL have port recip_mant  input  MANT_WIDTH  reciprocal mantissa m.
REQ-012 SHALL have port recip_shift  input  3  right-shift k; m*2^-k approximates 256/S.
REQ-013 SHALL have port out_valid  output  1  out_data holds a normalized probability.
REQ-014 SHALL have port out_data  output  MANT_WIDTH  normalized probability p_i, unsigned Q0.8.
REQ-015 SHALL have port out_last  output  1  marks element DEPTH-1 of the group.
REQ-016 SHALL have port out_ready  input  1  the downstream accepts out_data.

Function
REQ-017 SHALL implement the FSM states FILL, WAIT_RECIP and EMIT, with reset state FILL.
REQ-018 In FILL: in_ready=1; an element is accepted when in_valid&&in_ready, written to buffer[idx] and added to the running sum; idx increments.
REQ-019 On acceptance of element DEPTH-1: sum_out=S (including that element) and sum_valid=1 on the next cycle for exactly one cycle; the FSM moves to WAIT_RECIP.
REQ-020 In WAIT_RECIP and EMIT: in_ready=0, and in_valid is ignored.
REQ-021 recip_valid SHALL be ignored in FILL and EMIT.
REQ-022 In WAIT_RECIP, recip_valid=1 latches m and k; the FSM moves to EMIT; element 0 appears with out_valid=1 on the next cycle (1-cycle latency).
REQ-023 Arithmetic: P=e_i*m (2*MANT_WIDTH bits); R=(P + (k>0 ? 2^(k-1) : 0)) >> k; out_data=min(R, 2^MANT_WIDTH-1), i.e. round half-up then saturate.
REQ-024 out_data, out_valid and out_last SHALL be registered, and SHALL hold stable while out_valid&&!out_ready.
REQ-025 On out_valid&&out_ready, the next element is presented on the following cycle; with out_ready held high, the DEPTH outputs are back-to-back.
REQ-026 out_last=1 only with element DEPTH-1.
REQ-027 On acceptance of the last output: out_valid=0 next cycle, idx and sum are cleared, and the FSM returns to FILL; the first new element can be accepted on that next cycle.
REQ-028 The sum register SHALL never overflow: width MANT_WIDTH+log2(DEPTH) covers DEPTH*(2^MANT_WIDTH-1).
REQ-029 sum_out SHALL hold its value after the pulse until the next group completes.

Reset
REQ-030 While rst_n=0 (asynchronously): state=FILL, idx=0, sum=0, sum_out=0, sum_valid=0, out_valid=0, out_data=0, out_last=0, latched m/k=0; in_ready=1 after release.
REQ-031 Reset asserted mid-FILL, mid-WAIT_RECIP or mid-EMIT SHALL discard the partial group; no stale output may appear after release.

Verification
REQ-032 Uniform group: elements 64,64,64,64 -> sum_out=256 with a one-cycle sum_valid; then m=128,k=7 -> outputs 64,64,64,64 back-to-back, out_last on the 4th.
REQ-033 Saturation: elements 200,0,0,0 -> S=200; m=164,k=7 -> outputs 255,0,0,0.
REQ-034 Rounding/k=0: elements 3,1,0,0 with m=1,k=0 -> outputs 3,1,0,0; elements 3,1,0,0 with m=1,k=1 -> outputs 2,1,0,0.
REQ-035 Backpressure: out_ready held low for 3 cycles during element 1 -> out_data stable; sequence order and out_last position unchanged.
REQ-036 Protocol: recip_valid pulsed in FILL and in_valid driven in EMIT -> both ignored; a spurious recip_valid during EMIT does not alter m/k.
REQ-037 Reset mid-EMIT after 2 outputs -> out_valid=0 immediately; a new group of 4 gives correct sum_out and outputs.
